// File: rtl/ext_sram_ctl.sv
// External SRAM controller for a multiplexed 16-bit address/data bus.
// Each bus cycle is ALE0 (low address half), ALE1 (high address half), a data
// phase of WAIT_STATES+1 cycles and one recovery cycle. Word requests run two
// halfword bus cycles and return a single response.
//
// state | meaning
// IDLE  | ready for a request
// A0    | drive low bus address, ale0 high
// A1    | drive high bus address, ale1 high
// DATA  | data phase, wait-state down-counter running
// REC   | bus released; respond, or start the second half of a word
// ERR   | misaligned request, error response, no bus activity
module ext_sram_ctl #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  input  logic [15:0]       bus_din,
  output logic [15:0]       bus_dout,
  output logic              bus_isout,
  output logic              ale0,
  output logic              ale1,
  output logic              we,
  output logic              oe,
  output logic              ble,
  output logic              bhe
);

  typedef enum logic [2:0] {IDLE, A0, A1, DATA, REC, ERR} state_t;

  state_t            state, state_nxt;
  logic              rw_q, rw_nxt;
  logic [1:0]        size_q, size_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [31:0]       wdata_q, wdata_nxt;
  logic              half_q, half_nxt;
  logic [3:0]        cnt_q, cnt_nxt;
  logic [15:0]       lo_q, lo_nxt;

  logic        ready_nxt, valid_nxt, err_nxt, isout_nxt;
  logic        ale0_nxt, ale1_nxt, we_nxt, oe_nxt, ble_nxt, bhe_nxt;
  logic [15:0] dout_nxt;
  logic [31:0] rdata_nxt;
  logic        misaligned;

  // Next-state logic, then Moore output decode from the next state so every
  // output can be registered and still line up with the state it belongs to.
  always_comb begin
    state_nxt = state;
    rw_nxt    = rw_q;
    size_nxt  = size_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    half_nxt  = half_q;
    cnt_nxt   = cnt_q;
    lo_nxt    = lo_q;
    rdata_nxt = rsp_rdata;

    misaligned = (req_size == 2'b01 && req_addr[0]) ||
                 (req_size[1] && req_addr[1:0] != 2'b00);

    case (state)
      IDLE: begin
        if (req_valid) begin
          rw_nxt    = req_rw;
          size_nxt  = req_size;
          addr_nxt  = req_addr;
          wdata_nxt = req_wdata;
          half_nxt  = 1'b0;
          if (misaligned) begin
            state_nxt = ERR;
            rdata_nxt = 32'h0;
          end else begin
            state_nxt = A0;
          end
        end
      end
      ERR: state_nxt = IDLE;
      A0:  state_nxt = A1;
      A1: begin
        state_nxt = DATA;
        cnt_nxt   = 4'(WAIT_STATES);
      end
      DATA: begin
        if (cnt_q == 4'd0) begin
          state_nxt = REC;
          if (size_q[1]) begin
            if (!half_q) lo_nxt = bus_din;
            else         rdata_nxt = {bus_din, lo_q};
          end else if (size_q[0]) begin
            rdata_nxt = {16'h0, bus_din};
          end else begin
            rdata_nxt = {24'h0, addr_q[0] ? bus_din[15:8] : bus_din[7:0]};
          end
        end else begin
          cnt_nxt = cnt_q - 4'd1;
        end
      end
      REC: begin
        if (size_q[1] && !half_q) begin
          half_nxt  = 1'b1;
          addr_nxt  = addr_q + ADDR_W'(2);
          state_nxt = A0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    ready_nxt = 1'b0;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    isout_nxt = 1'b0;
    ale0_nxt  = 1'b0;
    ale1_nxt  = 1'b0;
    we_nxt    = 1'b0;
    oe_nxt    = 1'b0;
    ble_nxt   = 1'b0;
    bhe_nxt   = 1'b0;
    dout_nxt  = 16'h0;

    case (state_nxt)
      IDLE: ready_nxt = 1'b1;
      A0: begin
        ale0_nxt  = 1'b1;
        isout_nxt = 1'b1;
        dout_nxt  = addr_nxt[16:1];
      end
      A1: begin
        ale1_nxt  = 1'b1;
        isout_nxt = 1'b1;
        dout_nxt  = 16'(addr_nxt >> 17);
      end
      DATA: begin
        if (rw_nxt) begin
          we_nxt    = 1'b1;
          isout_nxt = 1'b1;
          if (size_nxt == 2'b00) begin
            dout_nxt = {wdata_nxt[7:0], wdata_nxt[7:0]};
            ble_nxt  = !addr_nxt[0];
            bhe_nxt  = addr_nxt[0];
          end else begin
            dout_nxt = half_nxt ? wdata_nxt[31:16] : wdata_nxt[15:0];
            ble_nxt  = 1'b1;
            bhe_nxt  = 1'b1;
          end
        end else begin
          oe_nxt  = 1'b1;
          ble_nxt = 1'b1;
          bhe_nxt = 1'b1;
        end
      end
      REC: valid_nxt = !(size_nxt[1] && !half_nxt);
      ERR: begin
        valid_nxt = 1'b1;
        err_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  // State and request context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      half_q  <= 1'b0;
      cnt_q   <= 4'd0;
      lo_q    <= 16'h0;
    end else begin
      state   <= state_nxt;
      rw_q    <= rw_nxt;
      size_q  <= size_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      half_q  <= half_nxt;
      cnt_q   <= cnt_nxt;
      lo_q    <= lo_nxt;
    end
  end

  // Registered outputs; reset drops every strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      bus_dout  <= 16'h0;
      bus_isout <= 1'b0;
      ale0      <= 1'b0;
      ale1      <= 1'b0;
      we        <= 1'b0;
      oe        <= 1'b0;
      ble       <= 1'b0;
      bhe       <= 1'b0;
    end else begin
      req_ready <= ready_nxt;
      rsp_valid <= valid_nxt;
      rsp_err   <= err_nxt;
      rsp_rdata <= rdata_nxt;
      bus_dout  <= dout_nxt;
      bus_isout <= isout_nxt;
      ale0      <= ale0_nxt;
      ale1      <= ale1_nxt;
      we        <= we_nxt;
      oe        <= oe_nxt;
      ble       <= ble_nxt;
      bhe       <= bhe_nxt;
    end
  end

endmodule

// File: doc/ext_sram_ctl.md
# ext_sram_ctl

Parametrised external SRAM bus controller for the multiplexed 16-bit address/data bus. It accepts byte, halfword and word requests from the core-side memory interface and runs a two-phase address cycle (ALE0 latches the low address half, ALE1 the high). A data phase with a configurable number of wait states follows, then a recovery cycle; word accesses are split into two halfword bus cycles. It adds byte-lane enables, wait-state control, misalignment errors and 32-bit transfers.

## Interface
- WAIT_STATES, 1, extra data-phase cycles, 0..15
- ADDR_W, 32, request address width, 18..33; bus address = byte address >> 1
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle; request accepted on valid & ready
- req_rw  in  1  1 = write
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  write data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read data, zero-extended, valid with rsp_valid
- rsp_err  out  1  misaligned request, valid with rsp_valid
- bus_din  in  16  bus read value
- bus_dout  out  16  bus drive value
- bus_isout  out  1  pad direction, 1 = drive bus_dout
- ale0, ale1, we, oe, ble, bhe  out  1 each  bus strobes, active high

## Operation
- All outputs are registered and reflect the current state; on reset every output is 0 except req_ready, which is 1. State returns to IDLE.
- States: IDLE, A0, A1, DATA, REC, ERR.
- IDLE: req_ready=1. On accept, latch rw/size/addr/wdata and clear the half index.
  - Misaligned request (halfword with addr[0]=1, or word with addr[1:0]≠0) goes to ERR.
  - Otherwise go to A0.
- ERR: one cycle; rsp_valid=1, rsp_err=1, rsp_rdata=0; no bus strobe. Then IDLE.
- A0: ale0=1, bus_isout=1, bus_dout=cur_addr[16:1].
- A1: ale1=1, bus_isout=1, bus_dout=cur_addr[ADDR_W-1:17] zero-extended to 16 bits.
- DATA: lasts WAIT_STATES+1 cycles, counted by a down-counter.
  - Write: we=1, bus_isout=1.
    - Halfword/word: bus_dout=current halfword, ble=bhe=1.
    - Byte: bus_dout={wdata[7:0],wdata[7:0]}, ble=!addr[0], bhe=addr[0].
  - Read: oe=1, bus_isout=0, ble=bhe=1.
  - bus_din is captured on the rising edge that ends the last DATA cycle.
- REC: all strobes 0, bus_isout=0, bus_dout=0.
  - Word with half index 0: set the index, cur_addr += 2, go to A0.
  - Otherwise: rsp_valid=1, go to IDLE.
- Read data:
  - Byte: rsp_rdata = selected lane, zero-extended (addr[0]=0 gives din[7:0], else din[15:8]).
  - Halfword: rsp_rdata = {16'b0, din}.
  - Word: rsp_rdata = {second half, first half}.
- Word writes put wdata[15:0] in the first half and wdata[31:16] in the second.
- rsp_rdata holds its value until the next response; rsp_err=0 on good responses.
- rsp_valid has no backpressure; the consumer must accept it.

## Timing
- Accept at edge 0 → A0 in cycle 1, A1 in cycle 2, DATA in cycles 3..3+W, REC in cycle 4+W with rsp_valid; W = WAIT_STATES.
- Latency, accept to rsp_valid: byte/halfword W+4, word 2W+8, error 1.
- req_ready returns 1 the cycle after rsp_valid, so the minimum issue interval is W+5 cycles per halfword.
- ale0 and ale1 are never high together; we and oe are never high together. bus_isout=0 for one full cycle (REC) between a read and the next drive.
- Reset mid-operation drops all strobes asynchronously; no response is issued for the aborted request.

## Test plan
- Reset, then idle 10 cycles → all outputs 0, req_ready=1, no strobe activity.
- W=1, halfword write at 0x0001_2344, data 0xBEEF → A0 bus_dout=0x91A2, A1 0x0000, DATA 2 cycles with bus_dout=0xBEEF, we=ble=bhe=1; rsp_valid at cycle 5, rsp_err=0.
- W=1, byte read at 0x0000_0003, bus_din=0xA55A in DATA → oe=1, ble=bhe=1, rsp_rdata=0x0000_00A5 at cycle 5; byte write 0x7E at 0x0000_0002 → bus_dout=0x7E7E, ble=1, bhe=0.
- W=1, word read at 0x0008_0000, bus_din 0x1234 then 0x5678 → A0/A1 = 0x0000/0x0004, then 0x0001/0x0004; single rsp_valid at cycle 10 with rsp_rdata=0x5678_1234.
- Halfword read at 0x0000_0101 → rsp_valid=rsp_err=1 at cycle 1, ale0 never asserted; the next valid request is accepted normally.
- W=0 back-to-back halfword reads → rsp_valid at cycle 4, next accept at cycle 5. Separately, rst_n low during DATA of a write → we and bus_isout drop immediately, no rsp_valid; after release req_ready=1.
